mips_cp0: RTL and testbench
===========================

MIPS_CP0 -- requirements
Module: mips_cp0

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset.
REQ-002 clk  in  1  rising-edge clock.
REQ-003 rst  in  1  synchronous active-high reset.
REQ-004 id_instr  in  32  instruction in ID; MFC0 and ERET are decoded here.
REQ-005 wb_instr  in  32  instruction in WB; MTC0 is decoded here.
REQ-006 wb_din  in  32  MTC0 write data.
REQ-007 ex_pc  in  32  PC of the EX-stage instruction, saved to EPC on interrupt entry.
REQ-008 intsrc  in  3  interrupt sources; index 2 is the highest priority.
REQ-009 INT  out  1  interrupt-taken request to the pipeline.
REQ-010 CP0ToReg  out  1  ID instruction is MFC0.
REQ-011 id_dout  out  32  MFC0 read data.
REQ-012 epc_out  out  32  current EPC.
REQ-013 eret  out  1  ID instruction is ERET.

Function
REQ-014 Decode SHALL be combinational on the following fields.
- MTC0: instr[31:21]=01000000100.
- MFC0: instr[31:21]=01000000000.
- Register select: rd=instr[15:11].
- ERET: instr==32'h42000018 exactly.
REQ-015 Registers SHALL be as follows.
- Status (rd 12): 32-bit R/W; bit0 = IE.
- Cause (rd 13): read-only; IP[2:0] at bits 12:10, all other bits read 0.
- EPC (rd 14): 32-bit R/W.
REQ-016 id_dout SHALL be the register selected by id_instr rd, combinationally; other rd values read 0.
REQ-017 CP0ToReg SHALL be 1 iff id_instr is MFC0, and eret SHALL be 1 iff id_instr is ERET.
REQ-018 An MTC0 in WB SHALL write wb_din to Status or EPC at the clock edge; writes to Cause and other rd values SHALL be ignored.
REQ-019 Each intsrc[i] rising edge SHALL set pending flag IP[i], even for pulses shorter than one clk period; a level held high SHALL NOT re-set IP[i] after it is cleared.
REQ-020 The block SHALL keep a 3-bit in-service mask ISV.
REQ-021 INT SHALL be combinational and equal 1 iff all of:
- IE=1;
- no ERET in ID;
- the highest set bit of IP is strictly higher than the highest set bit of ISV (an empty ISV counts as lowest).
REQ-022 At a clock edge with INT=1, for selected level k = highest IP bit:
- EPC<=ex_pc;
- IE<=0;
- ISV[k]<=1.
REQ-023 On ERET in ID, at the clock edge, for h = highest set ISV bit:
- ISV[h]<=0 and IP[h]<=0;
- Status and EPC SHALL be unchanged;
- with ISV=0, ERET SHALL change nothing.
REQ-024 A lower-priority IP bit SHALL remain pending during higher-level service and SHALL be taken once it outranks ISV with IE=1.
REQ-025 When an interrupt entry and an MTC0 to Status or EPC fall on the same edge, the entry SHALL win.
REQ-026 epc_out SHALL equal the EPC register at all times.
REQ-027 Each IP[i] SHALL be cleared by a clk-domain clear strobe that is registered and lasts one cycle; an intsrc edge arriving during that strobe MAY be lost.

Reset
REQ-028 Reset SHALL clear the following to 0: Status, EPC, IP, ISV and the clear strobes.
REQ-029 In consequence, INT SHALL be 0 and epc_out SHALL be 0 after reset.
REQ-030 CP0ToReg, eret and id_dout SHALL remain purely combinational from their inputs and registers.

Structure
REQ-031 A shared package SHALL hold:
- the opcode field constants (MTC0, MFC0, ERET);
- the register numbers 12, 13 and 14;
- the Cause IP bit offset 10;
- the IE bit index.
REQ-032 One sub-module, cp0_int_latch, SHALL be instantiated per source and contain:
- an edge-set flag clocked by intsrc[i];
- a clear path driven by the registered clk-domain clear strobe.

Verification
REQ-033 Reset, MTC0 Status=1, intsrc=3'b100 pulse of half a clk period -> IP=100, INT=1 until the next edge; then EPC=ex_pc (32'hdeadbeef), ISV=100, IE=0.
REQ-034 In service at 100, intsrc=3'b001 pulse -> IP=101, ISV stays 100; MFC0 rd 13 -> id_dout[12:10]=3'b100 with IE=0 (bit 10 also set once 001 is latched), CP0ToReg=1.
REQ-035 Re-enable IE, then ERET -> eret=1, INT=0 that cycle, IP=001, ISV=000; next edge takes level 0: ISV=001, EPC=ex_pc.
REQ-036 Re-enable IE, ERET with intsrc held at 001 -> IP=000, ISV=000, INT stays 0.
REQ-037 MTC0 rd 14 with 32'h00400000, then MFC0 rd 14 -> id_dout=epc_out=32'h00400000; MTC0 rd 13 -> Cause unchanged.
REQ-038 With IE=1, ISV=001 and a new intsrc=3'b010 edge -> nested entry: ISV=011; subsequent ERET clears only bit 1.

Source files
------------

// File: rtl/mips_cp0_pkg.sv
// Shared CP0 constants: instruction field codes, register numbers and bit positions.
// Also holds the priority helpers used to compare pending and in-service levels.
package mips_cp0_pkg;

  localparam logic [10:0] OP_MTC0    = 11'b01000000100;
  localparam logic [10:0] OP_MFC0    = 11'b01000000000;
  localparam logic [31:0] ERET_INSTR = 32'h42000018;

  localparam logic [4:0] REG_STATUS = 5'd12;
  localparam logic [4:0] REG_CAUSE  = 5'd13;
  localparam logic [4:0] REG_EPC    = 5'd14;

  localparam int CAUSE_IP_LSB = 10;
  localparam int STATUS_IE    = 0;

  // Level 0 means "nothing set"; levels 1..3 correspond to bits 0..2.
  function automatic logic [1:0] top_level(input logic [2:0] v);
    if (v[2])      return 2'd3;
    else if (v[1]) return 2'd2;
    else if (v[0]) return 2'd1;
    else           return 2'd0;
  endfunction

  function automatic logic [2:0] level_mask(input logic [1:0] lvl);
    case (lvl)
      2'd1:    return 3'b001;
      2'd2:    return 3'b010;
      2'd3:    return 3'b100;
      default: return 3'b000;
    endcase
  endfunction

endpackage

// File: rtl/mips_cp0_int_latch.sv
// Pending flag for one interrupt source: set by the source's rising edge,
// cleared asynchronously by a registered strobe from the clk domain.
module cp0_int_latch (
  input  logic src,
  input  logic clr,
  input  logic rst_q,
  output logic flag
);

  logic clear;
  assign clear = clr | rst_q;

  always_ff @(posedge src or posedge clear) begin
    if (clear) flag <= 1'b0;
    else       flag <= 1'b1;
  end

endmodule

// File: rtl/mips_cp0.sv
// Coprocessor 0: Status/Cause/EPC registers, MFC0/MTC0/ERET decode and
// a three-level nested interrupt controller with in-service tracking.
module mips_cp0
  import mips_cp0_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] id_instr,
  input  logic [31:0] wb_instr,
  input  logic [31:0] wb_din,
  input  logic [31:0] ex_pc,
  input  logic [2:0]  intsrc,
  output logic        INT,
  output logic        CP0ToReg,
  output logic [31:0] id_dout,
  output logic [31:0] epc_out,
  output logic        eret
);

  logic [31:0] status_q;
  logic [31:0] epc_q;
  logic [2:0]  isv_q;
  logic [2:0]  clr_q;
  logic        ip_rst_q;
  logic [2:0]  ip;
  logic        wb_is_mtc0;
  logic [4:0]  id_rd;
  logic [4:0]  wb_rd;
  logic [1:0]  ip_lvl;
  logic [1:0]  isv_lvl;
  logic [31:0] cause;

  assign CP0ToReg   = (id_instr[31:21] == OP_MFC0);
  assign eret       = (id_instr == ERET_INSTR);
  assign wb_is_mtc0 = (wb_instr[31:21] == OP_MTC0);
  assign id_rd      = id_instr[15:11];
  assign wb_rd      = wb_instr[15:11];

  assign ip_lvl  = top_level(ip);
  assign isv_lvl = top_level(isv_q);
  assign INT     = status_q[STATUS_IE] && !eret && (ip_lvl > isv_lvl);

  assign cause   = 32'(ip) << CAUSE_IP_LSB;
  assign epc_out = epc_q;

  always_comb begin
    id_dout = 32'd0;
    case (id_rd)
      REG_STATUS: id_dout = status_q;
      REG_CAUSE:  id_dout = cause;
      REG_EPC:    id_dout = epc_q;
      default:    id_dout = 32'd0;
    endcase
  end

  for (genvar i = 0; i < 3; i++) begin : g_ip
    cp0_int_latch u_latch (
      .src   (intsrc[i]),
      .clr   (clr_q[i]),
      .rst_q (ip_rst_q),
      .flag  (ip[i])
    );
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      status_q <= 32'd0;
      epc_q    <= 32'd0;
      isv_q    <= 3'b000;
      clr_q    <= 3'b000;
      ip_rst_q <= 1'b1;
    end else begin
      ip_rst_q <= 1'b0;
      clr_q    <= 3'b000;
      // Interrupt entry suppresses any same-edge MTC0; INT is never set with ERET in ID.
      if (INT) begin
        epc_q               <= ex_pc;
        status_q[STATUS_IE] <= 1'b0;
        isv_q               <= isv_q | level_mask(ip_lvl);
      end else begin
        if (wb_is_mtc0 && wb_rd == REG_STATUS) status_q <= wb_din;
        if (wb_is_mtc0 && wb_rd == REG_EPC)    epc_q    <= wb_din;
        if (eret && isv_lvl != 2'd0) begin
          isv_q <= isv_q & ~level_mask(isv_lvl);
          clr_q <= level_mask(isv_lvl);
        end
      end
    end
  end

endmodule

// File: tb/tb_mips_cp0.sv
// Directed bench for mips_cp0: register access, interrupt entry, nesting and ERET.
module tb_mips_cp0;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [31:0] id_instr = 32'd0;
  logic [31:0] wb_instr = 32'd0;
  logic [31:0] wb_din = 32'd0;
  logic [31:0] ex_pc = 32'd0;
  logic [2:0]  intsrc = 3'b000;
  logic        INT;
  logic        CP0ToReg;
  logic [31:0] id_dout;
  logic [31:0] epc_out;
  logic        eret;

  int n_vec = 0;
  int n_bad = 0;

  localparam logic [31:0] ERET_I = 32'h42000018;

  mips_cp0 dut (
    .clk      (clk),
    .rst      (rst),
    .id_instr (id_instr),
    .wb_instr (wb_instr),
    .wb_din   (wb_din),
    .ex_pc    (ex_pc),
    .intsrc   (intsrc),
    .INT      (INT),
    .CP0ToReg (CP0ToReg),
    .id_dout  (id_dout),
    .epc_out  (epc_out),
    .eret     (eret)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mfc0(input logic [4:0] rd);
    return {11'b01000000000, 5'd3, rd, 11'd0};
  endfunction

  function automatic logic [31:0] mtc0(input logic [4:0] rd);
    return {11'b01000000100, 5'd3, rd, 11'd0};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse(input logic [2:0] v);
    intsrc = v;
    #5;
    intsrc = 3'b000;
  endtask

  task automatic write_cp0(input logic [4:0] rd, input logic [31:0] d);
    wb_instr = mtc0(rd);
    wb_din   = d;
    tick();
    wb_instr = 32'd0;
    wb_din   = 32'd0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick(); tick();
    rst = 1'b0;
    tick();
    id_instr = mfc0(5'd12); #1;
    n_vec++; if (id_dout !== 32'd0) begin n_bad++; $display("FAIL reset_status: got %h want %h", id_dout, 32'd0); end
    n_vec++; if (CP0ToReg !== 1'b1) begin n_bad++; $display("FAIL reset_cp0toreg: got %b want 1", CP0ToReg); end
    n_vec++; if (INT !== 1'b0) begin n_bad++; $display("FAIL reset_int: got %b want 0", INT); end
    n_vec++; if (epc_out !== 32'd0) begin n_bad++; $display("FAIL reset_epc: got %h want 0", epc_out); end
    n_vec++; if (eret !== 1'b0) begin n_bad++; $display("FAIL reset_eret: got %b want 0", eret); end
    id_instr = mfc0(5'd13); #1;
    n_vec++; if (id_dout !== 32'd0) begin n_bad++; $display("FAIL reset_cause: got %h want 0", id_dout); end
  endtask

  task automatic test_entry();
    write_cp0(5'd12, 32'd1);
    id_instr = mfc0(5'd12); #1;
    n_vec++; if (id_dout !== 32'd1) begin n_bad++; $display("FAIL entry_status_wr: got %h want 1", id_dout); end
    n_vec++; if (INT !== 1'b0) begin n_bad++; $display("FAIL entry_idle_int: got %b want 0", INT); end
    tick();
    ex_pc = 32'hdeadbeef;
    pulse(3'b100);
    id_instr = mfc0(5'd13); #1;
    n_vec++; if (id_dout !== 32'h0000_1000) begin n_bad++; $display("FAIL entry_ip: got %h want 00001000", id_dout); end
    n_vec++; if (INT !== 1'b1) begin n_bad++; $display("FAIL entry_int: got %b want 1", INT); end
    tick();
    n_vec++; if (INT !== 1'b0) begin n_bad++; $display("FAIL entry_int_after: got %b want 0", INT); end
    n_vec++; if (epc_out !== 32'hdeadbeef) begin n_bad++; $display("FAIL entry_epc: got %h want deadbeef", epc_out); end
    id_instr = mfc0(5'd12); #1;
    n_vec++; if (id_dout !== 32'd0) begin n_bad++; $display("FAIL entry_ie_clr: got %h want 0", id_dout); end
  endtask

  task automatic test_lower_pending();
    tick();
    pulse(3'b001);
    id_instr = mfc0(5'd13); #1;
    n_vec++; if (id_dout !== 32'h0000_1400) begin n_bad++; $display("FAIL lower_ip: got %h want 00001400", id_dout); end
    n_vec++; if (CP0ToReg !== 1'b1) begin n_bad++; $display("FAIL lower_cp0toreg: got %b want 1", CP0ToReg); end
    write_cp0(5'd12, 32'd1);
    #1;
    n_vec++; if (INT !== 1'b0) begin n_bad++; $display("FAIL lower_masked_by_isv: got %b want 0", INT); end
    id_instr = ERET_I; #1;
    n_vec++; if (eret !== 1'b1) begin n_bad++; $display("FAIL lower_eret: got %b want 1", eret); end
    n_vec++; if (CP0ToReg !== 1'b0) begin n_bad++; $display("FAIL lower_eret_cp0toreg: got %b want 0", CP0ToReg); end
    n_vec++; if (INT !== 1'b0) begin n_bad++; $display("FAIL lower_eret_int: got %b want 0", INT); end
    tick();
    ex_pc = 32'h12345678;
    id_instr = mfc0(5'd13); #1;
    n_vec++; if (id_dout !== 32'h0000_0400) begin n_bad++; $display("FAIL lower_ip_after_eret: got %h want 00000400", id_dout); end
    n_vec++; if (INT !== 1'b1) begin n_bad++; $display("FAIL lower_int_ready: got %b want 1", INT); end
    tick();
    n_vec++; if (epc_out !== 32'h12345678) begin n_bad++; $display("FAIL lower_epc: got %h want 12345678", epc_out); end
    n_vec++; if (INT !== 1'b0) begin n_bad++; $display("FAIL lower_int_after: got %b want 0", INT); end
  endtask

  task automatic test_eret_held();
    write_cp0(5'd12, 32'd1);
    id_instr = mfc0(5'd13); #1;
    n_vec++; if (INT !== 1'b0) begin n_bad++; $display("FAIL held_same_level: got %b want 0", INT); end
    intsrc = 3'b001;
    id_instr = ERET_I;
    tick();
    id_instr = mfc0(5'd13); #1;
    n_vec++; if (id_dout !== 32'd0) begin n_bad++; $display("FAIL held_ip_clr: got %h want 0", id_dout); end
    n_vec++; if (INT !== 1'b0) begin n_bad++; $display("FAIL held_int: got %b want 0", INT); end
    tick(); tick();
    n_vec++; if (id_dout !== 32'd0) begin n_bad++; $display("FAIL held_no_reset: got %h want 0", id_dout); end
    n_vec++; if (INT !== 1'b0) begin n_bad++; $display("FAIL held_int_late: got %b want 0", INT); end
    intsrc = 3'b000;
  endtask

  task automatic test_epc_rw();
    write_cp0(5'd14, 32'h0040_0000);
    id_instr = mfc0(5'd14); #1;
    n_vec++; if (id_dout !== 32'h0040_0000) begin n_bad++; $display("FAIL epc_read: got %h want 00400000", id_dout); end
    n_vec++; if (epc_out !== 32'h0040_0000) begin n_bad++; $display("FAIL epc_out: got %h want 00400000", epc_out); end
    write_cp0(5'd13, 32'hffff_ffff);
    id_instr = mfc0(5'd13); #1;
    n_vec++; if (id_dout !== 32'd0) begin n_bad++; $display("FAIL cause_ro: got %h want 0", id_dout); end
    write_cp0(5'd5, 32'h0);
    id_instr = mfc0(5'd12); #1;
    n_vec++; if (id_dout !== 32'd1) begin n_bad++; $display("FAIL other_rd_wr: got %h want 1", id_dout); end
    id_instr = mfc0(5'd5); #1;
    n_vec++; if (id_dout !== 32'd0) begin n_bad++; $display("FAIL other_rd_rd: got %h want 0", id_dout); end
  endtask

  task automatic test_nested();
    tick();
    ex_pc = 32'haaaa_0000;
    pulse(3'b001); #1;
    n_vec++; if (INT !== 1'b1) begin n_bad++; $display("FAIL nest_l0_int: got %b want 1", INT); end
    tick();
    write_cp0(5'd12, 32'd1);
    ex_pc = 32'hbbbb_0000;
    pulse(3'b010);
    id_instr = mfc0(5'd13); #1;
    n_vec++; if (id_dout !== 32'h0000_0c00) begin n_bad++; $display("FAIL nest_ip: got %h want 00000c00", id_dout); end
    n_vec++; if (INT !== 1'b1) begin n_bad++; $display("FAIL nest_int: got %b want 1", INT); end
    tick();
    n_vec++; if (epc_out !== 32'hbbbb_0000) begin n_bad++; $display("FAIL nest_epc: got %h want bbbb0000", epc_out); end
    write_cp0(5'd12, 32'd1); #1;
    n_vec++; if (INT !== 1'b0) begin n_bad++; $display("FAIL nest_in_service: got %b want 0", INT); end
    id_instr = ERET_I;
    tick();
    id_instr = mfc0(5'd13); #1;
    n_vec++; if (id_dout !== 32'h0000_0400) begin n_bad++; $display("FAIL nest_eret_bit1: got %h want 00000400", id_dout); end
    n_vec++; if (INT !== 1'b0) begin n_bad++; $display("FAIL nest_isv0_kept: got %b want 0", INT); end
    n_vec++; if (epc_out !== 32'hbbbb_0000) begin n_bad++; $display("FAIL nest_eret_epc: got %h want bbbb0000", epc_out); end
    id_instr = ERET_I;
    tick();
    id_instr = mfc0(5'd13); #1;
    n_vec++; if (id_dout !== 32'd0) begin n_bad++; $display("FAIL nest_eret_bit0: got %h want 0", id_dout); end
  endtask

  task automatic test_entry_vs_mtc0();
    tick();
    ex_pc = 32'h2222_2222;
    pulse(3'b100);
    wb_instr = mtc0(5'd14);
    wb_din   = 32'h1111_1111; #1;
    n_vec++; if (INT !== 1'b1) begin n_bad++; $display("FAIL race_int: got %b want 1", INT); end
    tick();
    wb_instr = 32'd0;
    wb_din   = 32'd0;
    n_vec++; if (epc_out !== 32'h2222_2222) begin n_bad++; $display("FAIL race_epc: got %h want 22222222", epc_out); end
    id_instr = ERET_I;
    tick();
    write_cp0(5'd12, 32'h0000_0005);
    id_instr = ERET_I;
    tick();
    id_instr = mfc0(5'd12); #1;
    n_vec++; if (id_dout !== 32'h0000_0005) begin n_bad++; $display("FAIL idle_eret_status: got %h want 00000005", id_dout); end
    n_vec++; if (epc_out !== 32'h2222_2222) begin n_bad++; $display("FAIL idle_eret_epc: got %h want 22222222", epc_out); end
  endtask

  initial begin
    test_reset();
    test_entry();
    test_lower_pending();
    test_eret_held();
    test_epc_rw();
    test_nested();
    test_entry_vs_mtc0();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
